avmm_pio_ctrl: RTL and testbench
================================

AVMM_PIO_CTRL -- requirements
Module: avmm_pio_ctrl

Interface
REQ-001 SHALL have parameter OUT_W, default 8: width of the LED/output port.
REQ-002 SHALL have parameter IN_W, default 1: number of input channels (continue buttons), valid range 1..32.
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 50000: number of stable cycles required before an input change is accepted, minimum 2.
REQ-004 SHALL have port clk_clk, input, 1 bit: the single clock.
REQ-005 SHALL have port reset_reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port avs_address, input, 3 bits: word address of the register.
REQ-007 SHALL have ports avs_read and avs_write, input, 1 bit each: single-cycle access strobes.
REQ-008 SHALL have port avs_writedata, input, 32 bits: write data.
REQ-009 SHALL have port avs_readdata, output, 32 bits: read data.
REQ-010 SHALL have port avs_readdatavalid, output, 1 bit: qualifies avs_readdata.
REQ-011 SHALL have port irq, output, 1 bit: level interrupt.
REQ-012 SHALL have port pio_leds_export, output, OUT_W bits: driven output register.
REQ-013 SHALL have port pio_continue_export, input, IN_W bits: asynchronous raw inputs.

Function
REQ-014 SHALL pass each input bit through a 2-flop synchronizer before any other logic sees it.
REQ-015 SHALL keep one counter per channel, sized ceil(log2(DEBOUNCE_CYCLES+1)); the counter clears whenever the synced value equals the debounced value, otherwise increments.
REQ-016 SHALL load the synced value into the debounced bit and clear the counter when the counter reaches DEBOUNCE_CYCLES-1 with the mismatch still present; the debounced bit updates exactly DEBOUNCE_CYCLES cycles after the synced value first differs.
REQ-017 SHALL treat a glitch shorter than DEBOUNCE_CYCLES cycles as noise: counter clears, debounced bit unchanged.
REQ-018 SHALL set EDGE_CAP[i] on the cycle the debounced bit i changes 0->1; falling edges are ignored.
REQ-019 SHALL map registers as follows: 0 DATA_IN (RO, debounced inputs); 1 DATA_OUT (RW, OUT_W bits); 2 IRQ_MASK (RW, IN_W bits); 3 EDGE_CAP (read; write-1-to-clear); 4 OUTSET (WO, ORs writedata into DATA_OUT); 5 OUTCLR (WO, clears DATA_OUT bits set in writedata); 6-7 reserved, read 0, writes ignored.
REQ-020 SHALL have read latency exactly 1: avs_readdatavalid high for one cycle, with data, in the cycle after avs_read; zero-extend unused upper bits.
REQ-021 SHALL read 0 from OUTSET and OUTCLR.
REQ-022 SHALL ignore writedata bits above the register width.
REQ-023 SHALL give priority to the set when a rising edge and a W1C for the same EDGE_CAP bit occur in the same cycle: the bit stays 1.
REQ-024 SHALL give priority to write when avs_read and avs_write are asserted together: the write takes effect and no readdatavalid is produced.
REQ-025 SHALL drive irq from a register equal to OR(EDGE_CAP & IRQ_MASK), updated one cycle after either term changes.
REQ-026 SHALL drive pio_leds_export directly from the DATA_OUT register.

Reset
REQ-027 SHALL asynchronously clear, while reset_reset_n = 0: synchronizers, counters, debounced bits, DATA_OUT, IRQ_MASK, EDGE_CAP, irq, avs_readdata and avs_readdatavalid.
REQ-028 SHALL abandon a debounce in progress when reset asserts mid-count; after release, the count restarts from 0.
REQ-029 SHALL not produce a readdatavalid for a read issued in the cycle reset asserts.

Verification (bench DEBOUNCE_CYCLES=4, IN_W=2, OUT_W=8)
REQ-030 SHALL check: input bit 0 goes 0->1 and stays high -> DATA_IN reads 0x1, with the debounced change exactly 2+4 cycles after the input edge; EDGE_CAP reads 0x1.
REQ-031 SHALL check: a 3-cycle high pulse on input bit 1 -> DATA_IN and EDGE_CAP stay 0x0, irq stays 0.
REQ-032 SHALL check: write DATA_OUT=0x0F, then OUTSET=0xF0, then OUTCLR=0x03 -> pio_leds_export = 0xFC; DATA_OUT reads 0xFC with readdatavalid exactly 1 cycle after the read.
REQ-033 SHALL check: IRQ_MASK=0x1 with EDGE_CAP=0x1 -> irq=1; W1C 0x1 -> irq=0 one cycle later; a W1C coinciding with a new rising edge -> EDGE_CAP remains 0x1.
REQ-034 SHALL check: reset asserted asynchronously mid-debounce with DATA_OUT=0xAA -> pio_leds_export=0x00 immediately, and all registers read 0 after release.
REQ-035 SHALL check: a read of address 6 -> readdata 0x0; a simultaneous read and write to DATA_OUT -> write applied and no readdatavalid.

Source files
------------

// File: rtl/avmm_pio_ctrl.sv
// rtl/avmm_pio_ctrl.sv - Avalon-MM PIO: LED output register, debounced inputs, rising-edge capture, level IRQ
//
// Ports:
//   clk_clk, reset_reset_n     clock, asynchronous active-low reset
//   avs_address/read/write     register word address and single-cycle strobes
//   avs_writedata              write data (bits above a register's width are dropped)
//   avs_readdata/datavalid     registered read data, valid exactly one cycle after avs_read
//   irq                        registered OR(EDGE_CAP & IRQ_MASK)
//   pio_leds_export            DATA_OUT register
//   pio_continue_export        raw asynchronous inputs
//
// Register map (word addresses):
//   0 DATA_IN (RO)  1 DATA_OUT (RW)  2 IRQ_MASK (RW)  3 EDGE_CAP (W1C)
//   4 OUTSET (WO)   5 OUTCLR (WO)    6-7 reserved
// OUT_W and IN_W must not exceed 32 (they share the 32-bit data bus).

module avmm_pio_ctrl #(
  parameter int OUT_W           = 8,
  parameter int IN_W            = 1,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic [2:0]        avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  output logic [31:0]       avs_readdata,
  output logic              avs_readdatavalid,
  output logic              irq,
  output logic [OUT_W-1:0]  pio_leds_export,
  input  logic [IN_W-1:0]   pio_continue_export
);

  localparam int                 CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);

  localparam logic [2:0] A_DATA_IN  = 3'd0;
  localparam logic [2:0] A_DATA_OUT = 3'd1;
  localparam logic [2:0] A_IRQ_MASK = 3'd2;
  localparam logic [2:0] A_EDGE_CAP = 3'd3;
  localparam logic [2:0] A_OUTSET   = 3'd4;
  localparam logic [2:0] A_OUTCLR   = 3'd5;

  logic [IN_W-1:0]  sync1_q, sync2_q;
  logic [CNT_W-1:0] cnt_q [IN_W];
  logic [CNT_W-1:0] cnt_d [IN_W];
  logic [IN_W-1:0]  deb_q, deb_d;
  logic [OUT_W-1:0] data_out_q, data_out_d;
  logic [IN_W-1:0]  irq_mask_q, irq_mask_d;
  logic [IN_W-1:0]  edge_cap_q, edge_cap_d;
  logic             irq_q, irq_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             rvalid_q, rvalid_d;

  logic             wr_en, rd_en;
  logic [IN_W-1:0]  w1c;
  logic [31:0]      rd_mux;
  logic             unused_wdata;

  // Upper writedata bits are intentionally dropped for narrow registers.
  assign unused_wdata = ^avs_writedata;

  // A simultaneous read and write is treated as a write only.
  assign wr_en = avs_write;
  assign rd_en = avs_read & ~avs_write;

  // Debounce: each channel counts consecutive cycles where the synced input
  // disagrees with the accepted value; any agreement restarts the count.
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < IN_W; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        cnt_d[i] = '0;
        deb_d[i] = sync2_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
    end
  end

  always_comb begin
    data_out_d = data_out_q;
    irq_mask_d = irq_mask_q;
    w1c        = '0;
    if (wr_en) begin
      case (avs_address)
        A_DATA_OUT: data_out_d = avs_writedata[OUT_W-1:0];
        A_IRQ_MASK: irq_mask_d = avs_writedata[IN_W-1:0];
        A_EDGE_CAP: w1c        = avs_writedata[IN_W-1:0];
        A_OUTSET:   data_out_d = data_out_q | avs_writedata[OUT_W-1:0];
        A_OUTCLR:   data_out_d = data_out_q & ~avs_writedata[OUT_W-1:0];
        default:    ;
      endcase
    end
    // The set term is ORed in last so a new rising edge beats a same-cycle clear.
    edge_cap_d = (edge_cap_q & ~w1c) | (deb_d & ~deb_q);
    irq_d      = |(edge_cap_q & irq_mask_q);
  end

  always_comb begin
    rd_mux = '0;
    case (avs_address)
      A_DATA_IN:  rd_mux[IN_W-1:0]  = deb_q;
      A_DATA_OUT: rd_mux[OUT_W-1:0] = data_out_q;
      A_IRQ_MASK: rd_mux[IN_W-1:0]  = irq_mask_q;
      A_EDGE_CAP: rd_mux[IN_W-1:0]  = edge_cap_q;
      default:    rd_mux = '0;
    endcase
    rdata_d  = rd_en ? rd_mux : rdata_q;
    rvalid_d = rd_en;
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      for (int i = 0; i < IN_W; i++) cnt_q[i] <= '0;
      deb_q      <= '0;
      data_out_q <= '0;
      irq_mask_q <= '0;
      edge_cap_q <= '0;
      irq_q      <= 1'b0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
    end else begin
      sync1_q    <= pio_continue_export;
      sync2_q    <= sync1_q;
      for (int i = 0; i < IN_W; i++) cnt_q[i] <= cnt_d[i];
      deb_q      <= deb_d;
      data_out_q <= data_out_d;
      irq_mask_q <= irq_mask_d;
      edge_cap_q <= edge_cap_d;
      irq_q      <= irq_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
    end
  end

  assign avs_readdata      = rdata_q;
  assign avs_readdatavalid = rvalid_q;
  assign irq               = irq_q;
  assign pio_leds_export   = data_out_q;

endmodule

// File: tb/tb_avmm_pio_ctrl.sv
// tb/tb_avmm_pio_ctrl.sv - self-checking bench for avmm_pio_ctrl (DEBOUNCE_CYCLES=4, IN_W=2, OUT_W=8)

module tb_avmm_pio_ctrl;

  logic        clk;
  logic        rst_n;
  logic [2:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;
  logic        avs_readdatavalid;
  logic        irq;
  logic [7:0]  leds;
  logic [1:0]  cont;

  int checks = 0;
  int errors = 0;

  avmm_pio_ctrl #(.OUT_W(8), .IN_W(2), .DEBOUNCE_CYCLES(4)) dut (
    .clk_clk             (clk),
    .reset_reset_n       (rst_n),
    .avs_address         (avs_address),
    .avs_read            (avs_read),
    .avs_write           (avs_write),
    .avs_writedata       (avs_writedata),
    .avs_readdata        (avs_readdata),
    .avs_readdatavalid   (avs_readdatavalid),
    .irq                 (irq),
    .pio_leds_export     (leds),
    .pio_continue_export (cont)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        is_write;
    logic [2:0]  addr;
    logic [31:0] data;
    logic [31:0] exp_rd;
    logic [7:0]  exp_leds;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", nm, act, exp);
    end
  endtask

  task automatic do_write(input logic [2:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    avs_address = a; avs_writedata = d; avs_write = 1'b1;
    @(posedge clk); #1;
    avs_write = 1'b0;
  endtask

  task automatic do_read(input logic [2:0] a, input logic [31:0] exp, input string nm);
    @(posedge clk); #1;
    avs_address = a; avs_read = 1'b1;
    @(negedge clk);
    chk({nm, "_rv_early"}, 32'(avs_readdatavalid), 32'd0);
    @(posedge clk); #1;
    avs_read = 1'b0;
    @(negedge clk);
    chk({nm, "_rv"}, 32'(avs_readdatavalid), 32'd1);
    chk({nm, "_data"}, avs_readdata, exp);
    @(posedge clk);
    @(negedge clk);
    chk({nm, "_rv_late"}, 32'(avs_readdatavalid), 32'd0);
  endtask

  logic [2:0]  rst_addr [8];
  logic [31:0] rst_exp  [8];
  logic        irq_seen;

  initial begin
    vecs[0]  = '{1'b1, 3'd1, 32'h0000_000F, 32'h0, 8'h0F};
    vecs[1]  = '{1'b1, 3'd4, 32'h0000_00F0, 32'h0, 8'hFF};
    vecs[2]  = '{1'b1, 3'd5, 32'h0000_0003, 32'h0, 8'hFC};
    vecs[3]  = '{1'b0, 3'd1, 32'h0,         32'hFC, 8'hFC};
    vecs[4]  = '{1'b0, 3'd4, 32'h0,         32'h0, 8'hFC};
    vecs[5]  = '{1'b0, 3'd5, 32'h0,         32'h0, 8'hFC};
    vecs[6]  = '{1'b0, 3'd6, 32'h0,         32'h0, 8'hFC};
    vecs[7]  = '{1'b1, 3'd6, 32'hDEAD_BEEF, 32'h0, 8'hFC};
    vecs[8]  = '{1'b0, 3'd7, 32'h0,         32'h0, 8'hFC};
    vecs[9]  = '{1'b1, 3'd2, 32'hFFFF_FFFF, 32'h0, 8'hFC};
    vecs[10] = '{1'b0, 3'd2, 32'h0,         32'h3, 8'hFC};
    vecs[11] = '{1'b1, 3'd1, 32'h0001_2345, 32'h0, 8'h45};
    vecs[12] = '{1'b0, 3'd1, 32'h0,         32'h45, 8'h45};
    vecs[13] = '{1'b1, 3'd0, 32'h0000_0003, 32'h0, 8'h45};
    vecs[14] = '{1'b0, 3'd0, 32'h0,         32'h0, 8'h45};
    vecs[15] = '{1'b1, 3'd2, 32'h0,         32'h0, 8'h45};
    vecs[16] = '{1'b0, 3'd2, 32'h0,         32'h0, 8'h45};

    rst_addr = '{3'd1, 3'd2, 3'd3, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
    rst_exp  = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h3, 32'h3};

    rst_n = 1'b0; avs_address = '0; avs_read = 1'b0; avs_write = 1'b0;
    avs_writedata = '0; cont = '0;

    // Reset state
    @(posedge clk); @(negedge clk);
    chk("rst_readdata", avs_readdata, 32'h0);
    chk("rst_rvalid", 32'(avs_readdatavalid), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_leds", 32'(leds), 32'h0);
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Register map / output set-clear / reserved / width truncation
    for (int i = 0; i < NV; i++) begin
      if (vecs[i].is_write) begin
        do_write(vecs[i].addr, vecs[i].data);
      end else begin
        do_read(vecs[i].addr, vecs[i].exp_rd, $sformatf("vec%0d", i));
      end
      chk($sformatf("vec%0d_leds", i), 32'(leds), 32'(vecs[i].exp_leds));
    end

    // Simultaneous read and write: write wins, no readdatavalid
    @(posedge clk); #1;
    avs_address = 3'd1; avs_writedata = 32'h5A; avs_read = 1'b1; avs_write = 1'b1;
    @(posedge clk); #1;
    avs_read = 1'b0; avs_write = 1'b0;
    @(negedge clk);
    chk("rw_rvalid", 32'(avs_readdatavalid), 32'h0);
    chk("rw_leds", 32'(leds), 32'h5A);
    @(posedge clk); @(negedge clk);
    chk("rw_rvalid2", 32'(avs_readdatavalid), 32'h0);
    do_read(3'd1, 32'h5A, "rw_dout");

    // 3-cycle glitch on input 1 is rejected
    do_write(3'd2, 32'h3);
    @(posedge clk); #1 cont[1] = 1'b1;
    repeat (3) @(posedge clk);
    #1 cont[1] = 1'b0;
    irq_seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      irq_seen = irq_seen | irq;
    end
    chk("glitch_irq", 32'(irq_seen), 32'h0);
    do_read(3'd0, 32'h0, "glitch_din");
    do_read(3'd3, 32'h0, "glitch_ecap");
    do_write(3'd2, 32'h0);

    // Rising input 0: accepted 2+4 edges after input change, seen by a read one edge later
    @(posedge clk); #1;
    cont[0] = 1'b1; avs_address = 3'd0; avs_read = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); @(negedge clk);
      chk($sformatf("rise_rv_%0d", k), 32'(avs_readdatavalid), 32'h1);
      chk($sformatf("rise_din_%0d", k), avs_readdata, (k >= 7) ? 32'h1 : 32'h0);
    end
    avs_read = 1'b0;
    do_read(3'd3, 32'h1, "rise_ecap");
    chk("rise_irq_masked", 32'(irq), 32'h0);

    // IRQ follows mask and W1C with one cycle of delay
    do_write(3'd2, 32'h1);
    @(negedge clk);
    chk("irq_mask_lag", 32'(irq), 32'h0);
    @(negedge clk);
    chk("irq_set", 32'(irq), 32'h1);
    do_write(3'd3, 32'h1);
    @(negedge clk);
    chk("irq_w1c_lag", 32'(irq), 32'h1);
    @(negedge clk);
    chk("irq_clr", 32'(irq), 32'h0);

    // Falling edge is not captured
    @(posedge clk); #1 cont[0] = 1'b0;
    repeat (8) @(posedge clk);
    do_read(3'd0, 32'h0, "fall_din");
    do_read(3'd3, 32'h0, "fall_ecap");

    // W1C in the same cycle as a new rising edge: capture wins
    @(posedge clk); #1 cont[0] = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    avs_address = 3'd3; avs_writedata = 32'h1; avs_write = 1'b1;
    @(posedge clk); #1;
    avs_write = 1'b0;
    do_read(3'd3, 32'h1, "coll_ecap");
    do_read(3'd0, 32'h1, "coll_din");

    // Asynchronous reset mid-debounce; debounce restarts from zero after release
    do_write(3'd1, 32'hAA);
    chk("pre_rst_leds", 32'(leds), 32'hAA);
    @(posedge clk); #1 cont[1] = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0; avs_read = 1'b1; avs_address = 3'd0;
    #1;
    chk("arst_leds", 32'(leds), 32'h0);
    chk("arst_irq", 32'(irq), 32'h0);
    chk("arst_rvalid", 32'(avs_readdatavalid), 32'h0);
    @(negedge clk);
    chk("arst_rvalid_neg", 32'(avs_readdatavalid), 32'h0);
    @(posedge clk); @(negedge clk);
    chk("arst_rvalid_hold", 32'(avs_readdatavalid), 32'h0);
    rst_n = 1'b1;
    avs_address = rst_addr[0];
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); @(negedge clk);
      chk($sformatf("post_rst_rv_%0d", k), 32'(avs_readdatavalid), 32'h1);
      chk($sformatf("post_rst_rd_%0d", k), avs_readdata, rst_exp[k-1]);
      if (k < 8) avs_address = rst_addr[k];
    end
    avs_read = 1'b0;
    do_read(3'd3, 32'h3, "post_rst_ecap");
    do_read(3'd1, 32'h0, "post_rst_dout");
    chk("post_rst_irq", 32'(irq), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
